// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the pipeline stage register: default geometry,
// channel index names, state encodings and the occupancy decode.
package pipe_stage_reg_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_NCH   = 4;
  localparam int DEF_AUX_W = 3;

  localparam int CH_CTRL = 0;
  localparam int CH_PC2  = 1;
  localparam int CH_ALU  = 2;
  localparam int CH_DMEM = 3;

  // Encoding equals the number of held entries, so occ is a plain cast.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  function automatic logic [1:0] occ_of(input state_e s);
    return 2'(s);
  endfunction

endpackage

// File: rtl/pipe_entry.sv
// One payload-wide storage entry with write enable and synchronous clear;
// used as both the head and the skid slot of the stage register.
module pipe_entry #(
  parameter int PW = 1
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          we,
  input  logic [PW-1:0] d,
  output logic [PW-1:0] q
);

  logic [PW-1:0] q_d, q_q;

  // NOTE: the hold value is assigned first so every path writes q_d and no latch is inferred.
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (we) begin
      q_d = d;
    end
  end

  // NOTE: storage is zeroed through clr rather than a dedicated reset, so a cleared slot
  // and a reset slot are the same all-zero bubble.
  always_ff @(posedge clk) begin
    q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Two-entry skid-buffered pipeline stage register carrying NCH data channels,
// an aux field and an error tag, with valid/ready on both sides and flush.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NCH   = DEF_NCH,
  parameter int AUX_W = DEF_AUX_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [AUX_W-1:0]     in_aux,
  input  logic                 in_err,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NCH*WIDTH-1:0] out_data,
  output logic [AUX_W-1:0]     out_aux,
  output logic                 out_err,
  output logic [1:0]           occ
);

  localparam int DW = NCH * WIDTH;
  localparam int PW = DW + AUX_W + 1;

  state_e        state_q, state_d;
  logic          accept, deliver;
  logic          head_we, head_clr, head_from_skid;
  logic          skid_we, skid_clr;
  logic [PW-1:0] in_pl, head_in, head_pl, skid_pl;

  assign in_pl     = {in_data, in_aux, in_err};
  assign in_ready  = (state_q != ST_FULL) & ~rst;
  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = in_valid & in_ready;
  assign deliver   = out_valid & out_ready;

  always_comb begin
    state_d        = state_q;
    head_we        = 1'b0;
    head_clr       = 1'b0;
    head_from_skid = 1'b0;
    skid_we        = 1'b0;
    skid_clr       = 1'b0;
    if (rst || flush) begin
      state_d  = ST_EMPTY;
      head_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d = ST_ONE;
            head_we = 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && !deliver) begin
            state_d = ST_FULL;
            skid_we = 1'b1;
          end else if (deliver && !accept) begin
            state_d  = ST_EMPTY;
            head_clr = 1'b1;
          end else if (accept && deliver) begin
            head_we = 1'b1;
          end
        end
        ST_FULL: begin
          // Skid moves up; in_ready is low here so no accept competes.
          if (deliver) begin
            state_d        = ST_ONE;
            head_we        = 1'b1;
            head_from_skid = 1'b1;
            skid_clr       = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  assign head_in = head_from_skid ? skid_pl : in_pl;

  pipe_entry #(.PW(PW)) u_head (
    .clk (clk),
    .clr (head_clr),
    .we  (head_we),
    .d   (head_in),
    .q   (head_pl)
  );

  pipe_entry #(.PW(PW)) u_skid (
    .clk (clk),
    .clr (skid_clr),
    .we  (skid_we),
    .d   (in_pl),
    .q   (skid_pl)
  );

  assign out_data = head_pl[PW-1 -: DW];
  assign out_aux  = head_pl[AUX_W:1];
  assign out_err  = head_pl[0] & out_valid;
  assign occ      = occ_of(state_q);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg: reset, streaming,
// backpressure, flush, error tagging and simultaneous events.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, in_err;
  logic [63:0] in_data, out_data;
  logic [2:0]  in_aux, out_aux;
  logic        out_valid, out_ready, out_err;
  logic [1:0]  occ;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_stage_reg dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_aux    (in_aux),
    .in_err    (in_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_aux   (out_aux),
    .out_err   (out_err),
    .occ       (occ)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Distinct value per channel so channel swaps are caught.
  function automatic logic [63:0] mk(input logic [15:0] v);
    return {v + 16'h3000, v + 16'h2000, v + 16'h1000, v};
  endfunction

  task automatic drive(input logic vld, input logic [15:0] v, input logic err);
    in_valid = vld;
    in_data  = mk(v);
    in_aux   = v[2:0];
    in_err   = err;
  endtask

  // Advance one edge and settle so outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_head(input string tag, input logic [15:0] v);
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_data"}, out_data, mk(v));
    check({tag, "_aux"}, 64'(out_aux), 64'(v[2:0]));
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b1, 16'h1234, 1'b0);
    step(); step();
    check("rst_occ", 64'(occ), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_out_err", 64'(out_err), 64'd0);

    rst = 1'b0;
    #1 check("release_in_ready", 64'(in_ready), 64'd1);
    step();
    check("first_ch0", 64'(out_data[15:0]), 64'h1234);
    expect_head("first", 16'h1234);
    check("first_occ", 64'(occ), 64'd1);
    drive(1'b0, 16'h0, 1'b0); out_ready = 1'b1;
    step();
    check("drain_occ", 64'(occ), 64'd0);
    check("drain_bubble", out_data, 64'd0);

    // Streaming: accept and deliver every cycle, head tracks input with one edge latency.
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 16'(i), 1'b0);
      step();
      check($sformatf("stream_data_%0d", i), out_data, mk(16'(i)));
      check($sformatf("stream_occ_%0d", i), 64'(occ), 64'd1);
    end
    drive(1'b0, 16'h0, 1'b0);
    step();
    check("stream_end_occ", 64'(occ), 64'd0);

    // Backpressure: hold out_ready low for 3 cycles with input pending.
    drive(1'b1, 16'h0011, 1'b0);
    step();
    out_ready = 1'b0;
    drive(1'b1, 16'h0022, 1'b0);
    step();
    check("bp_fill_occ", 64'(occ), 64'd2);
    check("bp_in_ready", 64'(in_ready), 64'd0);
    drive(1'b1, 16'h0033, 1'b0);
    step(); step();
    check("bp_hold_occ", 64'(occ), 64'd2);
    expect_head("bp_hold_head", 16'h0011);
    out_ready = 1'b1;
    step();
    expect_head("bp_skid", 16'h0022);
    check("bp_skid_occ", 64'(occ), 64'd1);
    check("bp_reopen", 64'(in_ready), 64'd1);
    step();
    expect_head("bp_new", 16'h0033);
    drive(1'b0, 16'h0, 1'b0);
    step();
    check("bp_empty", 64'(occ), 64'd0);

    // Flush when full: pending input in the flush cycle is dropped.
    out_ready = 1'b0;
    drive(1'b1, 16'h0044, 1'b0); step();
    drive(1'b1, 16'h0055, 1'b0); step();
    check("fl_full", 64'(occ), 64'd2);
    flush = 1'b1;
    drive(1'b1, 16'h0066, 1'b1);
    step();
    flush = 1'b0;
    check("fl_occ", 64'(occ), 64'd0);
    check("fl_out_valid", 64'(out_valid), 64'd0);
    check("fl_out_data", out_data, 64'd0);
    check("fl_out_err", 64'(out_err), 64'd0);
    drive(1'b0, 16'h0, 1'b0); out_ready = 1'b1;
    step();
    check("fl_no_ghost", 64'(out_valid), 64'd0);

    // Error tags travel with their own entry only.
    drive(1'b1, 16'h00a1, 1'b0); step();
    check("err_e0", 64'(out_err), 64'd0);
    drive(1'b1, 16'h00a2, 1'b1); step();
    check("err_e1", 64'(out_err), 64'd1);
    expect_head("err_e1_head", 16'h00a2);
    drive(1'b1, 16'h00a3, 1'b0); step();
    check("err_e2", 64'(out_err), 64'd0);
    drive(1'b0, 16'h0, 1'b0); step();
    check("err_empty", 64'(out_err), 64'd0);

    // Simultaneous accept and deliver in ONE, then flush during a deliver.
    drive(1'b1, 16'h0077, 1'b0); step();
    drive(1'b1, 16'h0088, 1'b0);
    check("sim_deliver_pending", 64'(out_valid & out_ready), 64'd1);
    step();
    check("sim_occ", 64'(occ), 64'd1);
    expect_head("sim_head", 16'h0088);
    drive(1'b0, 16'h0, 1'b0);
    flush = 1'b1;
    check("fd_deliver", 64'(out_valid & out_ready), 64'd1);
    step();
    flush = 1'b0;
    check("fd_occ", 64'(occ), 64'd0);
    check("fd_out_valid", 64'(out_valid), 64'd0);

    // Reset mid-transfer with both entries held.
    out_ready = 1'b0;
    drive(1'b1, 16'h0099, 1'b1); step();
    drive(1'b1, 16'h00aa, 1'b0); step();
    check("mr_full", 64'(occ), 64'd2);
    rst = 1'b1;
    #1 check("mr_in_ready_rst", 64'(in_ready), 64'd0);
    step();
    check("mr_occ", 64'(occ), 64'd0);
    check("mr_out_data", out_data, 64'd0);
    check("mr_out_err", 64'(out_err), 64'd0);
    rst = 1'b0;
    #1 check("mr_in_ready_rel", 64'(in_ready), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
